// File: rtl/maxpool_frame_ctrl.sv
// maxpool_frame_ctrl: control sequencer for one 2x2/stride-2 maxpool layer.
// Admits one IMG_SIZE x IMG_SIZE frame, then counts pooled outputs until done or error.
`default_nettype none

module maxpool_frame_ctrl #(
  parameter int IMG_SIZE      = 104,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pool_valid_in,
  input  logic             pool_valid_out,
  output logic             out_valid,
  output logic             out_last,
  output logic [CNT_W-1:0] in_col,
  output logic [CNT_W-1:0] in_row,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int OUT_TOTAL = IMG_SIZE * IMG_SIZE / 4;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(IMG_SIZE - 1);
  localparam logic [CNT_W-1:0] OUT_TOT_C = CNT_W'(OUT_TOTAL);
  localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_TOTAL - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] tcnt;
  logic             err_q;

  logic accept;
  logic last_px;
  logic start_acc;
  logic out_full;
  logic count_out;
  logic spurious;
  logic drain_to;
  logic busy_w;

  always_comb begin
    state_nxt = state;
    busy_w    = (state == S_RUN) || (state == S_DRAIN);
    start_acc = (state == S_IDLE) && start;
    accept    = (state == S_RUN) && in_valid;
    last_px   = accept && (col == LAST_IDX) && (row == LAST_IDX);
    out_full  = (out_cnt == OUT_TOT_C);
    count_out = pool_valid_out && busy_w && !out_full;
    // Outputs outside a frame, or beyond the expected total, are never forwarded.
    spurious  = pool_valid_out && (!busy_w || out_full);
    drain_to  = (state == S_DRAIN) && !out_full && (tcnt == TO_LAST);

    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_px) state_nxt = S_DRAIN;
      S_DRAIN: if (out_full || (tcnt == TO_LAST)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      out_cnt <= '0;
      tcnt    <= '0;
    end else if (start_acc) begin
      col     <= '0;
      row     <= '0;
      out_cnt <= '0;
      tcnt    <= '0;
    end else begin
      if (accept) begin
        if (col == LAST_IDX) begin
          col <= '0;
          row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (count_out) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if ((state == S_DRAIN) && !out_full && (tcnt != TO_LAST)) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // A fault seen in the same cycle as a start still wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (spurious || drain_to) begin
      err_q <= 1'b1;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end
  end

  assign in_ready      = (state == S_RUN);
  assign pool_valid_in = accept;
  assign out_valid     = count_out;
  assign out_last      = count_out && (out_cnt == OUT_LAST);
  assign in_col        = col;
  assign in_row        = row;
  assign out_count     = out_cnt;
  assign busy          = busy_w;
  assign done          = (state == S_DONE);
  assign err           = err_q;

endmodule

`default_nettype wire
